serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
//   Parallel-in, serial-out frame transmitter: the sending end of the single-bit serial link whose
//   receiving end samples one bit per bit period into flip-flops. Accepts a DATA_W-bit word over a
//   load/ready handshake and shifts it out LSB first on tx as start, data, [parity], stop.
//   Sits between the lab datapath (word producer) and the serial pin; one frame in flight at a time.
// PARAMETERS
//   CLKS_PER_BIT  default 4  clk cycles per serial bit period; legal range >= 1
//   DATA_W        default 8  data bits per frame; legal range 1..16
//   PARITY_EN     default 0  1 = append even-parity bit after data; 0 = no parity bit
// PORTS
//   clk    in   1       system clock; all state updates on posedge clk
//   rs     in   1       reset, asynchronous, active-high
//   d      in   DATA_W  word to transmit; sampled only on an accepted load
//   load   in   1       request to send d; accepted when load && ready at posedge clk
//   ready  out  1       1 = idle, a load is accepted this cycle
//   busy   out  1       1 = frame in progress (always ~ready)
//   tx     out  1       serial line; idles high
//   done   out  1       one-cycle pulse marking completion of the stop bit
// BEHAVIOUR
//   Reset (rs=1, takes effect without a clk edge): state=IDLE, tx=1, ready=1, busy=0, done=0,
//     shift register, bit counter and period counter = 0. Any frame in flight is discarded; no done.
//   Outputs are registered; no combinational path from inputs to outputs.
//   States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
//   IDLE: tx=1, ready=1. On load&&ready at edge E: capture d, compute even parity (XOR of the
//     captured bits), go to START; ready=0, busy=1 from E.
//   START: tx=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after E (latency 1 cycle).
//   DATA: DATA_W bits, bit 0 first, each held CLKS_PER_BIT cycles; the bit counter runs 0..DATA_W-1.
//   PARITY: tx=parity bit for CLKS_PER_BIT cycles (1 when the data has an odd number of ones).
//   STOP: tx=1 for CLKS_PER_BIT cycles. The edge ending STOP sets state=IDLE, ready=1, busy=0,
//     done=1. done clears on the following edge.
//   Frame length: (DATA_W + 2 + PARITY_EN) * CLKS_PER_BIT cycles of tx activity.
//   load while busy: ignored and not queued. Changes on d while busy: no effect on the frame.
//   Back-to-back: with load held high, the next word is accepted in the done cycle. Frames are
//     separated by exactly one idle-high cycle.
//   Period counter: clog2(CLKS_PER_BIT)+1 bits, counts 0..CLKS_PER_BIT-1 and never wraps
//     past terminal. CLKS_PER_BIT=1 advances one bit per cycle.
//   A load that coincides with rs=1 is lost.
// TESTING
//   1. Mid-frame rs pulse with no clk edge -> tx=1, ready=1, busy=0, done=0 immediately.
//   2. CLKS_PER_BIT=4, PARITY_EN=0, d=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1 (start, data LSB first,
//      stop), each held 4 cycles, first 0 on the cycle after accept. done pulses 40 cycles after accept.
//   3. PARITY_EN=1: d=8'h07 -> parity bit 1; d=8'h03 -> parity bit 0. Frame is 44 cycles.
//   4. load held high with d=8'h55 then 8'hAA -> second start bit 1 cycle after the done pulse.
//      Toggling d mid-frame leaves the 8'h55 bit pattern unchanged.
//   5. rs asserted during data bit 3 -> tx=1 at once, no done. The next load sends a complete,
//      correct frame.
//   6. CLKS_PER_BIT=1, d=8'hFF -> tx low for 1 cycle then high for 9 cycles, done 10 cycles after accept.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. One frame in flight; all outputs come from flops.
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rs,
    input  logic [DATA_W-1:0] d,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              tx,
    output logic              done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  periodCnt_q;
    logic [BIT_W-1:0]  bitCnt_q;
    logic              parity_q;
    logic              ready_q;
    logic              busy_q;
    logic              tx_q;
    logic              done_q;
    logic              periodEnd;

    always_comb begin
        shift_d   = shift_q >> 1;
        periodEnd = (periodCnt_q == CNT_LAST);
    end

    // tx is loaded with the next bit on the same edge that ends the current bit period
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            periodCnt_q <= '0;
            bitCnt_q    <= '0;
            parity_q    <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load && ready_q) begin
                        shift_q     <= d;
                        parity_q    <= ^d;
                        periodCnt_q <= '0;
                        bitCnt_q    <= '0;
                        tx_q        <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    if (periodEnd) begin
                        periodCnt_q <= '0;
                        tx_q        <= shift_q[0];
                        state_q     <= DATA;
                    end else begin
                        periodCnt_q <= periodCnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (periodEnd) begin
                        periodCnt_q <= '0;
                        if (bitCnt_q == BIT_LAST) begin
                            bitCnt_q <= '0;
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bitCnt_q <= bitCnt_q + BIT_W'(1);
                            shift_q  <= shift_d;
                            tx_q     <= shift_d[0];
                        end
                    end else begin
                        periodCnt_q <= periodCnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (periodEnd) begin
                        periodCnt_q <= '0;
                        tx_q        <= 1'b1;
                        state_q     <= STOP;
                    end else begin
                        periodCnt_q <= periodCnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (periodEnd) begin
                        periodCnt_q <= '0;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        periodCnt_q <= periodCnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign tx    = tx_q;
    assign done  = done_q;
endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: three instances (4 clk/bit, 4 clk/bit with parity, 1 clk/bit).
// Drivers push time-stamped per-cycle expectations; a negedge monitor pops and compares them.
module tb_serial_frame_tx;
    localparam int N = 3;

    typedef struct {
        int id;
        int cyc;
        bit busy;
        bit tx;
        bit done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rsV    [N];
    logic [7:0] dV     [N];
    logic       loadV  [N];
    logic       readyV [N];
    logic       busyV  [N];
    logic       txV    [N];
    logic       doneV  [N];

    exp_t expQ[$];
    int   cyc    = 0;
    int   checks = 0;
    int   passes = 0;
    bit   monOn  = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(0)) dutA (
        .clk(clk), .rs(rsV[0]), .d(dV[0]), .load(loadV[0]),
        .ready(readyV[0]), .busy(busyV[0]), .tx(txV[0]), .done(doneV[0]));

    serial_frame_tx #(.CLKS_PER_BIT(4), .DATA_W(8), .PARITY_EN(1)) dutB (
        .clk(clk), .rs(rsV[1]), .d(dV[1]), .load(loadV[1]),
        .ready(readyV[1]), .busy(busyV[1]), .tx(txV[1]), .done(doneV[1]));

    serial_frame_tx #(.CLKS_PER_BIT(1), .DATA_W(8), .PARITY_EN(0)) dutC (
        .clk(clk), .rs(rsV[2]), .d(dV[2]), .load(loadV[2]),
        .ready(readyV[2]), .busy(busyV[2]), .tx(txV[2]), .done(doneV[2]));

    function automatic int cpbOf(int id);
        return (id == 2) ? 1 : 4;
    endfunction

    function automatic bit parOf(int id);
        return (id == 1);
    endfunction

    task automatic checkOutput(string name, bit ok, string detail);
        checks++;
        if (ok) passes++;
        else $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Expected line for a frame accepted on edge e: one entry per busy cycle, then the done cycle
    function automatic void pushFrame(int id, logic [7:0] w, int e);
        bit   bits[$];
        int   cpb = cpbOf(id);
        exp_t x;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(w[i]);
        if (parOf(id)) bits.push_back(^w);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++) begin
            for (int k = 0; k < cpb; k++) begin
                x.id = id; x.cyc = e + b * cpb + k; x.busy = 1'b1; x.tx = bits[b]; x.done = 1'b0;
                expQ.push_back(x);
            end
        end
        x.id = id; x.cyc = e + bits.size() * cpb; x.busy = 1'b0; x.tx = 1'b1; x.done = 1'b1;
        expQ.push_back(x);
    endfunction

    function automatic void flushExp(int id);
        for (int i = expQ.size() - 1; i >= 0; i--)
            if (expQ[i].id == id) expQ.delete(i);
    endfunction

    task automatic monitorDut(int id);
        int   idx = -1;
        exp_t e;
        bit   ok;
        foreach (expQ[i]) if (idx < 0 && expQ[i].id == id) idx = i;
        if (busyV[id] || doneV[id]) begin
            if (idx < 0) begin
                checkOutput($sformatf("dut%0d_unexpected", id), 1'b0,
                    $sformatf("busy=%b done=%b at cycle %0d, required idle", busyV[id], doneV[id], cyc));
            end else begin
                e = expQ[idx];
                expQ.delete(idx);
                ok = (e.cyc == cyc) && (busyV[id] == e.busy) && (readyV[id] == !e.busy)
                     && (txV[id] == e.tx) && (doneV[id] == e.done);
                checkOutput($sformatf("dut%0d_frame", id), ok,
                    $sformatf("cyc=%0d tx=%b done=%b busy=%b ready=%b, required cyc=%0d tx=%b done=%b busy=%b ready=%b",
                              cyc, txV[id], doneV[id], busyV[id], readyV[id],
                              e.cyc, e.tx, e.done, e.busy, !e.busy));
            end
        end else if (idx >= 0 && expQ[idx].cyc <= cyc) begin
            checkOutput($sformatf("dut%0d_missing", id), 1'b0,
                $sformatf("idle at cycle %0d, required busy=%b tx=%b done=%b",
                          cyc, expQ[idx].busy, expQ[idx].tx, expQ[idx].done));
            expQ.delete(idx);
        end else begin
            checkOutput($sformatf("dut%0d_idle", id), txV[id] == 1'b1 && readyV[id] == 1'b1,
                $sformatf("tx=%b ready=%b at cycle %0d, required tx=1 ready=1", txV[id], readyV[id], cyc));
        end
    endtask

    always @(negedge clk) begin
        if (monOn)
            for (int id = 0; id < N; id++) monitorDut(id);
    end

    // Returns at a negedge where the instance is ready, or reports the timeout
    task automatic waitReady(int id, output bit ok);
        int t = 0;
        @(negedge clk);
        while (!readyV[id] && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = readyV[id];
        if (!ok) checkOutput($sformatf("dut%0d_ready_timeout", id), 1'b0, "ready=0 after 200 cycles, required 1");
    endtask

    task automatic waitDone(int id);
        int t = 0;
        while (!doneV[id] && t < 200) begin
            @(negedge clk);
            t++;
        end
        checkOutput($sformatf("dut%0d_done_seen", id), doneV[id] == 1'b1,
            $sformatf("done=%b after %0d cycles, required 1", doneV[id], t));
    endtask

    task automatic applyStimulus(int id, logic [7:0] w);
        bit ok;
        waitReady(id, ok);
        if (!ok) return;
        pushFrame(id, w, cyc + 1);
        dV[id]    = w;
        loadV[id] = 1'b1;
        @(negedge clk);
        loadV[id] = 1'b0;
        waitDone(id);
    endtask

    // Starts a frame, then pulses rs between clock edges k+1 cycles into it
    task automatic applyAbort(int id, logic [7:0] w, int k);
        bit ok;
        waitReady(id, ok);
        if (!ok) return;
        pushFrame(id, w, cyc + 1);
        dV[id]    = w;
        loadV[id] = 1'b1;
        @(negedge clk);
        loadV[id] = 1'b0;
        repeat (k) @(negedge clk);
        @(posedge clk);
        #1 rsV[id] = 1'b1;
        #1;
        checkOutput($sformatf("dut%0d_async_reset", id),
            txV[id] == 1'b1 && readyV[id] == 1'b1 && busyV[id] == 1'b0 && doneV[id] == 1'b0,
            $sformatf("tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                      txV[id], readyV[id], busyV[id], doneV[id]));
        flushExp(id);
        #1 rsV[id] = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    // load held high: 8'h55 then 8'hAA, with d scrambled while the first frame is on the line
    task automatic applyHeld(int id);
        bit ok;
        int t = 0;
        waitReady(id, ok);
        if (!ok) return;
        pushFrame(id, 8'h55, cyc + 1);
        dV[id]    = 8'h55;
        loadV[id] = 1'b1;
        @(negedge clk);
        while (!readyV[id] && t < 200) begin
            dV[id] = t[0] ? 8'h0F : 8'hF0;
            @(negedge clk);
            t++;
        end
        if (!readyV[id]) begin
            checkOutput($sformatf("dut%0d_held_timeout", id), 1'b0, "ready=0 after 200 cycles, required 1");
            loadV[id] = 1'b0;
            return;
        end
        pushFrame(id, 8'hAA, cyc + 1);
        dV[id] = 8'hAA;
        @(negedge clk);
        loadV[id] = 1'b0;
        waitDone(id);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rsV[i]   = 1'b1;
            loadV[i] = 1'b0;
            dV[i]    = 8'h00;
        end
        #12;
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("dut%0d_reset_state", i),
                txV[i] == 1'b1 && readyV[i] == 1'b1 && busyV[i] == 1'b0 && doneV[i] == 1'b0,
                $sformatf("tx=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                          txV[i], readyV[i], busyV[i], doneV[i]));
        for (int i = 0; i < N; i++) rsV[i] = 1'b0;
        @(negedge clk);
        monOn = 1'b1;

        applyStimulus(0, 8'hA5);
        applyAbort(0, 8'h3C, 8);
        applyAbort(0, 8'h5A, 16);
        applyStimulus(0, 8'hC3);
        applyHeld(0);

        applyStimulus(1, 8'h07);
        applyStimulus(1, 8'h03);

        applyStimulus(2, 8'hFF);
        applyStimulus(2, 8'h00);
        applyStimulus(2, 8'h01);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size() == 0,
            $sformatf("%0d entries left, required 0", expQ.size()));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
